// File: rtl/par_ser_pkg.sv
// -----------------------------------------------------------------------------
// par_ser_pkg
// Shared serial-PHY definitions used by the transmitter (par_ser) and the
// matching receiver: default comma/idle byte, default preamble length, default
// input buffer depth and the link state encoding.
// -----------------------------------------------------------------------------
package par_ser_pkg;

  // Comma byte: sent while idle and repeated during the sync preamble.
  localparam logic [7:0]  PHY_IDLE_BYTE  = 8'hBC;
  // Number of complete comma bytes sent before data is accepted.
  localparam int unsigned PHY_BC_SYNC    = 4;
  // Default number of entries in the transmit input buffer.
  localparam int unsigned PHY_FIFO_DEPTH = 2;

  // Link state shared by both ends of the link.
  typedef enum logic {
    PHY_SYNC   = 1'b0,
    PHY_ACTIVE = 1'b1
  } phy_state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/par_ser_if.sv
// -----------------------------------------------------------------------------
// par_ser_if
// Byte-in / bit-out bundle of the parallel-to-serial transmitter.
//   data_in    [7:0] parallel byte from upstream
//   valid_in         data_in valid this cycle
//   ready_out        transmitter accepts data_in this cycle
//   data_out         serial bit stream, MSB first
//   byte_start       data_out carries bit 7 of a byte
//   active           sync preamble complete, data transfer enabled
// master: upstream / test side.  slave: the transmitter.
// -----------------------------------------------------------------------------
interface par_ser_if;

  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       byte_start;
  logic       active;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  data_out,
    input  byte_start,
    input  active
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output data_out,
    output byte_start,
    output active
  );

endinterface

// File: rtl/par_ser_byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Small synchronous byte FIFO holding bytes waiting for serialisation.
//   clk_32f          bit clock
//   reset            asynchronous active-low reset, empties the FIFO
//   i_push / i_data  write a byte (ignored when full)
//   i_pop            drop the head byte (ignored when empty)
//   o_data           current head byte, valid while not empty
//   o_full / o_empty occupancy flags
// DEPTH must be a power of two (pointers wrap naturally), minimum 2.
// -----------------------------------------------------------------------------
module byte_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop  && !o_empty;

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk_32f) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is read combinationally so the serialiser can load it on the same
  // edge it decides to pop; the buffer is only a few entries deep.
  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/par_ser.sv
// -----------------------------------------------------------------------------
// par_ser
// Parallel-to-serial transmitter. After reset it sends BC_SYNC comma bytes,
// then serialises bytes from a small input FIFO MSB first, one bit per clock,
// inserting IDLE_BYTE whenever the FIFO is empty at a byte boundary.
//   clk_32f  bit clock (only clock)
//   reset    asynchronous active-low reset
//   bus      par_ser_if.slave: data_in, valid_in, ready_out, data_out,
//            byte_start, active
// -----------------------------------------------------------------------------
module par_ser
  import par_ser_pkg::*;
#(
  parameter int unsigned BC_SYNC    = PHY_BC_SYNC,
  parameter logic [7:0]  IDLE_BYTE  = PHY_IDLE_BYTE,
  parameter int unsigned FIFO_DEPTH = PHY_FIFO_DEPTH
) (
  input  logic     clk_32f,
  input  logic     reset,
  par_ser_if.slave bus
);

  localparam int unsigned   CW      = cnt_width(BC_SYNC);
  localparam logic [CW-1:0] BC_LAST = CW'(BC_SYNC - 1);
  localparam logic [CW-1:0] BC_MAX  = CW'(BC_SYNC);

  phy_state_e    r_state;
  phy_state_e    w_state_next;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_cur_byte;
  logic [CW-1:0] r_bc_cnt;
  logic          r_data_out;
  logic          r_byte_start;

  logic          w_byte_end;
  logic          w_sync_done;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_next_byte;
  logic [7:0]    w_fifo_head;
  logic          w_fifo_full;
  logic          w_fifo_empty;

  // Edge on which the last bit of the current byte goes out.
  assign w_byte_end  = (r_bit_idx == 3'd0);
  assign w_sync_done = w_byte_end && (r_bc_cnt == BC_LAST);

  // --- FSM: state register ----------------------------------------------------
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_state <= PHY_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --- FSM: next state (ACTIVE is left only through reset) --------------------
  always_comb begin
    w_state_next = r_state;
    if ((r_state == PHY_SYNC) && w_sync_done) begin
      w_state_next = PHY_ACTIVE;
    end
  end

  // --- FSM: outputs ------------------------------------------------------------
  // The pop decision looks at pre-edge FIFO contents, so a byte pushed on a
  // byte-end edge into an empty FIFO waits for the following byte slot.
  always_comb begin
    w_ready     = 1'b0;
    w_pop       = 1'b0;
    w_next_byte = IDLE_BYTE;
    if (r_state == PHY_ACTIVE) begin
      w_ready = !w_fifo_full;
      w_pop   = w_byte_end && !w_fifo_empty;
      if (!w_fifo_empty) begin
        w_next_byte = w_fifo_head;
      end
    end
  end

  // ready_out depends on registered state only, never on valid_in.
  assign w_push = bus.valid_in && w_ready;

  // --- Serialiser -------------------------------------------------------------
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_bit_idx    <= 3'd7;
      r_cur_byte   <= IDLE_BYTE;
      r_data_out   <= 1'b0;
      r_byte_start <= 1'b0;
    end else begin
      r_data_out   <= r_cur_byte[r_bit_idx];
      r_byte_start <= (r_bit_idx == 3'd7);
      r_bit_idx    <= r_bit_idx - 3'd1;
      if (w_byte_end) begin
        r_cur_byte <= w_next_byte;
      end
    end
  end

  // --- Preamble counter, saturating at BC_SYNC --------------------------------
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_bc_cnt <= '0;
    end else if (w_byte_end && (r_bc_cnt != BC_MAX)) begin
      r_bc_cnt <= r_bc_cnt + CW'(1);
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_32f (clk_32f),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (bus.data_in),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign bus.ready_out  = w_ready;
  assign bus.data_out   = r_data_out;
  assign bus.byte_start = r_byte_start;
  assign bus.active     = (r_state == PHY_ACTIVE);

endmodule

// File: tb/tb_par_ser.sv
// -----------------------------------------------------------------------------
// tb_par_ser
// Bench for par_ser. The reference model works in byte slots: edge n after
// reset release (1-based) carries bit 7-((n-1)%8) of slot (n-1)/8; every 8th
// edge chooses the next slot byte (comma during the preamble, else FIFO head
// or comma), and a bounded queue stands in for the input buffer.
// -----------------------------------------------------------------------------
module tb_par_ser;

  localparam int         BC_SYNC    = 4;
  localparam logic [7:0] IDLE       = 8'hBC;
  localparam int         DEPTH      = 2;
  localparam int         SYNC_EDGES = 8 * BC_SYNC;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;

  par_ser_if bus();

  par_ser #(
    .BC_SYNC    (BC_SYNC),
    .IDLE_BYTE  (IDLE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_32f = ~clk_32f;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         n;
  logic [7:0] q[$];
  logic [7:0] slot_byte;
  logic       slot_is_data;
  logic       accepted;
  logic       exp_dout, exp_bs, exp_act, exp_rdy;

  // Observed outputs, sampled on the falling edge
  logic       obs_dout, obs_bs, obs_act, obs_rdy;
  logic [7:0] obs_sr;

  task automatic reset_model();
    n            = 0;
    q.delete();
    slot_byte    = IDLE;
    slot_is_data = 1'b0;
    obs_sr       = 8'h00;
  endtask

  // One clock: drive inputs, advance the model over the rising edge, sample.
  task automatic tick(input logic v, input logic [7:0] d);
    logic ready_now;
    ready_now    = (n >= SYNC_EDGES) && (q.size() < DEPTH);
    accepted     = v && ready_now;
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge clk_32f);
    n++;
    exp_dout = slot_byte[7 - ((n - 1) % 8)];
    exp_bs   = ((n - 1) % 8 == 0);
    if (n % 8 == 0) begin
      if ((n > SYNC_EDGES) && (q.size() > 0)) begin
        slot_byte    = q.pop_front();
        slot_is_data = 1'b1;
      end else begin
        slot_byte    = IDLE;
        slot_is_data = 1'b0;
      end
    end
    if (accepted) begin
      q.push_back(d);
      $display("push n=%0d data=%02h", n, d);
    end
    exp_act = (n >= SYNC_EDGES);
    exp_rdy = exp_act && (q.size() < DEPTH);
    @(negedge clk_32f);
    obs_dout = bus.data_out;
    obs_bs   = bus.byte_start;
    obs_act  = bus.active;
    obs_rdy  = bus.ready_out;
    obs_sr   = {obs_sr[6:0], obs_dout};
  endtask

  task automatic test_reset();
    @(negedge clk_32f);
    reset = 1'b0;
    #1;
    total += 4;
    if (bus.data_out !== 1'b0)   begin bad++; $display("FAIL reset_dout got=%b want=0", bus.data_out); end
    if (bus.byte_start !== 1'b0) begin bad++; $display("FAIL reset_bs got=%b want=0", bus.byte_start); end
    if (bus.active !== 1'b0)     begin bad++; $display("FAIL reset_active got=%b want=0", bus.active); end
    if (bus.ready_out !== 1'b0)  begin bad++; $display("FAIL reset_ready got=%b want=0", bus.ready_out); end
    repeat (3) @(negedge clk_32f);
    reset_model();
    reset = 1'b1;
  endtask

  task automatic test_sync_preamble();
    int first_act = -1;
    for (int i = 0; i < SYNC_EDGES; i++) begin
      tick(1'b0, 8'($urandom_range(0, 255)));
      total++;
      if (obs_dout !== exp_dout || obs_bs !== exp_bs || obs_act !== exp_act || obs_rdy !== exp_rdy) begin
        bad++;
        $display("FAIL sync n=%0d dout=%b/%b bs=%b/%b act=%b/%b rdy=%b/%b", n,
                 obs_dout, exp_dout, obs_bs, exp_bs, obs_act, exp_act, obs_rdy, exp_rdy);
      end
      if (obs_act === 1'b1 && first_act < 0) first_act = n;
      if (n % 8 == 0) begin
        total++;
        if (obs_sr !== IDLE) begin bad++; $display("FAIL sync_byte n=%0d got=%02h want=%02h", n, obs_sr, IDLE); end
      end
    end
    total++;
    if (first_act != SYNC_EDGES) begin
      bad++; $display("FAIL active_edge got=%0d want=%0d", first_act, SYNC_EDGES);
    end
  endtask

  task automatic test_two_bytes();
    int first_load;
    first_load = ((n + 2) / 8 + 1) * 8;
    tick(1'b1, 8'h5A);
    tick(1'b1, 8'hC3);
    total++;
    if (obs_rdy !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", obs_rdy); end
    for (int i = 0; i < 32; i++) begin
      tick(1'b0, 8'h00);
      total++;
      if (obs_dout !== exp_dout || obs_bs !== exp_bs || obs_act !== exp_act || obs_rdy !== exp_rdy) begin
        bad++;
        $display("FAIL two_bytes n=%0d dout=%b/%b bs=%b/%b act=%b/%b rdy=%b/%b", n,
                 obs_dout, exp_dout, obs_bs, exp_bs, obs_act, exp_act, obs_rdy, exp_rdy);
      end
      if (n == first_load + 8) begin
        total++;
        if (obs_sr !== 8'h5A) begin bad++; $display("FAIL byte_5a got=%02h want=5a", obs_sr); end
      end
      if (n == first_load + 16) begin
        total++;
        if (obs_sr !== 8'hC3) begin bad++; $display("FAIL byte_c3 got=%02h want=c3", obs_sr); end
      end
      if (n == first_load + 24) begin
        total++;
        if (obs_sr !== IDLE) begin bad++; $display("FAIL idle_after got=%02h want=%02h", obs_sr, IDLE); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx[$];
    int         rx_n[$];
    int         k = 0;
    int         cycles = 0;
    while (cycles < 600) begin
      if (k < 16) tick(1'b1, 8'(k));
      else        tick(1'b0, 8'h00);
      cycles++;
      if (accepted) k++;
      total++;
      if (obs_dout !== exp_dout || obs_bs !== exp_bs || obs_act !== exp_act || obs_rdy !== exp_rdy) begin
        bad++;
        $display("FAIL b2b n=%0d dout=%b/%b bs=%b/%b act=%b/%b rdy=%b/%b", n,
                 obs_dout, exp_dout, obs_bs, exp_bs, obs_act, exp_act, obs_rdy, exp_rdy);
      end
      if (n % 8 == 0 && obs_sr !== IDLE) begin
        rx.push_back(obs_sr);
        rx_n.push_back(n);
      end
      if (k >= 16 && q.size() == 0 && n % 8 == 0 && !slot_is_data) break;
    end
    total++;
    if (k != 16 || rx.size() != 16) begin
      bad++; $display("FAIL b2b_count pushed=%0d got=%0d want=16", k, rx.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (rx[i] !== 8'(i)) begin bad++; $display("FAIL b2b_order idx=%0d got=%02h want=%02h", i, rx[i], 8'(i)); end
        if (i > 0) begin
          total++;
          if (rx_n[i] - rx_n[i-1] != 8) begin
            bad++; $display("FAIL b2b_gap idx=%0d got=%0d want=8", i, rx_n[i] - rx_n[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_zero_edge_push();
    int budget = 0;
    int e;
    while (!(q.size() == 0 && n % 8 == 7) && budget < 64) begin
      tick(1'b0, 8'h00);
      budget++;
    end
    total++;
    if (budget >= 64) begin
      bad++; $display("FAIL zero_edge_wait got=timeout want=aligned");
    end else begin
      tick(1'b1, 8'h81);
      e = n;
      for (int i = 0; i < 16; i++) begin
        tick(1'b0, 8'h00);
        total++;
        if (obs_dout !== exp_dout || obs_bs !== exp_bs || obs_act !== exp_act || obs_rdy !== exp_rdy) begin
          bad++;
          $display("FAIL zero_edge n=%0d dout=%b/%b bs=%b/%b act=%b/%b rdy=%b/%b", n,
                   obs_dout, exp_dout, obs_bs, exp_bs, obs_act, exp_act, obs_rdy, exp_rdy);
        end
        if (n == e + 8) begin
          total++;
          if (obs_sr !== IDLE) begin bad++; $display("FAIL zero_edge_idle got=%02h want=%02h", obs_sr, IDLE); end
        end
        if (n == e + 9) begin
          total++;
          if (obs_bs !== 1'b1 || obs_dout !== 1'b1) begin
            bad++; $display("FAIL zero_edge_latency bs=%b dout=%b want=1/1", obs_bs, obs_dout);
          end
        end
        if (n == e + 16) begin
          total++;
          if (obs_sr !== 8'h81) begin bad++; $display("FAIL zero_edge_byte got=%02h want=81", obs_sr); end
        end
      end
    end
  endtask

  task automatic test_random();
    logic       v;
    logic [7:0] d;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 7) == 0) ? IDLE : 8'($urandom_range(0, 255));
      tick(v, d);
      total++;
      if (obs_dout !== exp_dout || obs_bs !== exp_bs || obs_act !== exp_act || obs_rdy !== exp_rdy) begin
        bad++;
        $display("FAIL random n=%0d dout=%b/%b bs=%b/%b act=%b/%b rdy=%b/%b", n,
                 obs_dout, exp_dout, obs_bs, exp_bs, obs_act, exp_act, obs_rdy, exp_rdy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    int k = 0;
    while (!(slot_is_data && q.size() == DEPTH && n % 8 == 4) && budget < 200) begin
      tick(q.size() < DEPTH, 8'hA0 + 8'(k));
      if (accepted) k++;
      budget++;
      total++;
      if (obs_dout !== exp_dout || obs_bs !== exp_bs || obs_act !== exp_act || obs_rdy !== exp_rdy) begin
        bad++;
        $display("FAIL fill n=%0d dout=%b/%b bs=%b/%b act=%b/%b rdy=%b/%b", n,
                 obs_dout, exp_dout, obs_bs, exp_bs, obs_act, exp_act, obs_rdy, exp_rdy);
      end
    end
    total++;
    if (budget >= 200) begin
      bad++; $display("FAIL reset_mid_wait got=timeout want=queued");
    end
    reset = 1'b0;
    #1;
    total += 4;
    if (bus.data_out !== 1'b0)   begin bad++; $display("FAIL mid_reset_dout got=%b want=0", bus.data_out); end
    if (bus.byte_start !== 1'b0) begin bad++; $display("FAIL mid_reset_bs got=%b want=0", bus.byte_start); end
    if (bus.active !== 1'b0)     begin bad++; $display("FAIL mid_reset_active got=%b want=0", bus.active); end
    if (bus.ready_out !== 1'b0)  begin bad++; $display("FAIL mid_reset_ready got=%b want=0", bus.ready_out); end
    repeat (2) @(negedge clk_32f);
    reset_model();
    reset = 1'b1;
    // valid_in held high during the preamble must be ignored.
    for (int i = 0; i < SYNC_EDGES + 40; i++) begin
      tick(n < SYNC_EDGES, 8'h77);
      total++;
      if (obs_dout !== exp_dout || obs_bs !== exp_bs || obs_act !== exp_act || obs_rdy !== exp_rdy) begin
        bad++;
        $display("FAIL after_reset n=%0d dout=%b/%b bs=%b/%b act=%b/%b rdy=%b/%b", n,
                 obs_dout, exp_dout, obs_bs, exp_bs, obs_act, exp_act, obs_rdy, exp_rdy);
      end
      if (n % 8 == 0) begin
        total++;
        if (obs_sr !== IDLE) begin bad++; $display("FAIL after_reset_byte n=%0d got=%02h want=%02h", n, obs_sr, IDLE); end
      end
    end
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    reset_model();
    test_reset();
    test_sync_preamble();
    test_two_bytes();
    test_back_to_back();
    test_zero_edge_push();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
